// File: rtl/udp_tx_scheduler.sv
// UDP TX scheduler: counts beats into the data FIFO, queues packet lengths (splitting at
// MAX_BEATS) and paces them to the framer with a programmable gap. Optional stats: UDP_SCHED_STATS_EN.
module udp_tx_scheduler #(
  parameter int SWIDTH    = 512,
  parameter int MAX_BEATS = 22,
  parameter int LEN_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SWIDTH-1:0] AXIS_IN_TDATA,
  input  logic              AXIS_IN_TVALID,
  input  logic              AXIS_IN_TLAST,
  output logic              AXIS_IN_TREADY,
  output logic [SWIDTH-1:0] AXIS_OUT_TDATA,
  output logic              AXIS_OUT_TVALID,
  output logic              AXIS_OUT_TLAST,
  input  logic              AXIS_OUT_TREADY,
  output logic [15:0]       AXIS_LEN_TDATA,
  output logic              AXIS_LEN_TVALID,
  input  logic              AXIS_LEN_TREADY,
  input  logic              TX_DONE,
  input  logic [15:0]       IFG_CYCLES,
  input  logic              ENABLE,
  output logic              LEN_FULL,
  output logic              OVERSPLIT
`ifdef UDP_SCHED_STATS_EN
  ,
  output logic [31:0]       PKT_COUNT,
  output logic [15:0]       SPLIT_COUNT,
  output logic [31:0]       STALL_CYCLES
`endif
);
  localparam int BPB = SWIDTH / 8;
  localparam int AW  = $clog2(LEN_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  state_t      state;
  logic [9:0]  beat_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] mem [LEN_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic        len_valid, len_full, oversplit;
  logic        last_beat, out_hs, push, pop, forced;
  logic [15:0] push_len;

  assign last_beat = (beat_cnt == 10'(MAX_BEATS - 1));
  assign AXIS_OUT_TDATA  = AXIS_IN_TDATA;
  assign AXIS_OUT_TVALID = AXIS_IN_TVALID & ~len_full & ~reset;
  assign AXIS_IN_TREADY  = AXIS_OUT_TREADY & ~len_full & ~reset;
  assign AXIS_OUT_TLAST  = AXIS_IN_TLAST | last_beat;

  assign out_hs   = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
  assign push     = out_hs & AXIS_OUT_TLAST;
  assign forced   = out_hs & last_beat & ~AXIS_IN_TLAST;
  assign pop      = len_valid & AXIS_LEN_TREADY;
  assign push_len = (16'(beat_cnt) + 16'd1) * 16'(BPB);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  assign AXIS_LEN_TDATA  = mem[rd_ptr];
  assign AXIS_LEN_TVALID = len_valid;
  assign LEN_FULL        = len_full;
  assign OVERSPLIT       = oversplit;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      len_full  <= 1'b0;
      oversplit <= 1'b0;
    end else begin
      if (out_hs) beat_cnt <= AXIS_OUT_TLAST ? 10'd0 : beat_cnt + 10'd1;
      if (push)   wr_ptr   <= wr_ptr + AW'(1);
      if (pop)    rd_ptr   <= rd_ptr + AW'(1);
      if (forced) oversplit <= 1'b1;
      count    <= count_nxt;
      len_full <= (count_nxt == (AW+1)'(LEN_DEPTH));
    end
  end

  // One length in flight: the next is held back until the framer reports TX_DONE plus the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_valid <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (ENABLE && count != '0) begin
          state     <= ISSUE;
          len_valid <= 1'b1;
        end
        ISSUE: if (AXIS_LEN_TREADY) begin
          state     <= BUSY;
          len_valid <= 1'b0;
        end
        BUSY: if (TX_DONE) begin
          gap_cnt <= IFG_CYCLES;
          state   <= (IFG_CYCLES != 16'd0) ? GAP : IDLE;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt == 16'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      PKT_COUNT    <= '0;
      SPLIT_COUNT  <= '0;
      STALL_CYCLES <= '0;
    end else begin
      if (pop) PKT_COUNT <= PKT_COUNT + 32'd1;
      if (forced && SPLIT_COUNT != 16'hFFFF) SPLIT_COUNT <= SPLIT_COUNT + 16'd1;
      if (AXIS_IN_TVALID && len_full && STALL_CYCLES != 32'hFFFF_FFFF)
        STALL_CYCLES <= STALL_CYCLES + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: table of packets with expected lengths fed to a scoreboard,
// plus hand sequences for latency, gap timing, full FIFO, enable and reset.
module tb_udp_tx_scheduler;
  localparam int SWIDTH = 512;
  localparam int MAXB   = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [SWIDTH-1:0] AXIS_IN_TDATA;
  logic              AXIS_IN_TVALID, AXIS_IN_TLAST, AXIS_IN_TREADY;
  logic [SWIDTH-1:0] AXIS_OUT_TDATA;
  logic              AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TREADY;
  logic [15:0]       AXIS_LEN_TDATA;
  logic              AXIS_LEN_TVALID, AXIS_LEN_TREADY;
  logic              TX_DONE, ENABLE, LEN_FULL, OVERSPLIT;
  logic [15:0]       IFG_CYCLES;
`ifdef UDP_SCHED_STATS_EN
  logic [31:0]       PKT_COUNT, STALL_CYCLES;
  logic [15:0]       SPLIT_COUNT;
`endif

  udp_tx_scheduler #(.SWIDTH(SWIDTH), .MAX_BEATS(MAXB), .LEN_DEPTH(16)) dut (
    .clk(clk), .reset(rst),
    .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID),
    .AXIS_IN_TLAST(AXIS_IN_TLAST), .AXIS_IN_TREADY(AXIS_IN_TREADY),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
    .AXIS_OUT_TLAST(AXIS_OUT_TLAST), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .AXIS_LEN_TDATA(AXIS_LEN_TDATA), .AXIS_LEN_TVALID(AXIS_LEN_TVALID),
    .AXIS_LEN_TREADY(AXIS_LEN_TREADY), .TX_DONE(TX_DONE), .IFG_CYCLES(IFG_CYCLES),
    .ENABLE(ENABLE), .LEN_FULL(LEN_FULL), .OVERSPLIT(OVERSPLIT)
`ifdef UDP_SCHED_STATS_EN
    , .PKT_COUNT(PKT_COUNT), .SPLIT_COUNT(SPLIT_COUNT), .STALL_CYCLES(STALL_CYCLES)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          beats;
    int          nlen;
    logic [15:0] len [3];
    logic        split;
  } vec_t;

  vec_t        tbl [5];
  logic [15:0] exp_q [$];
  int          checks = 0, errors = 0;
  int          hs_cnt = 0, done_cnt = 0, ebc = 0;
  logic        in_hs, out_tlast_s, hold;
  logic [15:0] hold_data;
  logic [SWIDTH-1:0] out_data_s;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: sample at negedge (scoreboard + AXIS hold rule), return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    in_hs       = AXIS_IN_TVALID && AXIS_IN_TREADY;
    out_tlast_s = AXIS_OUT_TLAST;
    out_data_s  = AXIS_OUT_TDATA;
    if (hold && !rst) check_eq("len_hold", {15'd0, AXIS_LEN_TVALID, AXIS_LEN_TDATA}, {15'd0, 1'b1, hold_data});
    hold      = AXIS_LEN_TVALID && !AXIS_LEN_TREADY && !rst;
    hold_data = AXIS_LEN_TDATA;
    if (AXIS_LEN_TVALID && AXIS_LEN_TREADY && !rst) begin
      if (exp_q.size() == 0) check_eq("len_unexpected", {16'd0, AXIS_LEN_TDATA}, 32'hFFFF_FFFF);
      else check_eq("len_data", {16'd0, AXIS_LEN_TDATA}, {16'd0, exp_q.pop_front()});
      hs_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int n, input bit last);
    logic [SWIDTH-1:0] d;
    logic              tl;
    for (int i = 0; i < n; i++) begin
      d  = {16{$urandom()}};
      tl = last && (i == n - 1);
      AXIS_IN_TVALID = 1'b1;
      AXIS_IN_TLAST  = tl;
      AXIS_IN_TDATA  = d;
      in_hs = 1'b0;
      for (int k = 0; k < 200 && !in_hs; k++) tick();
      check_eq("beat_accept", {31'd0, in_hs}, 1);
      check_eq("pass_data", {31'd0, out_data_s == d}, 1);
      check_eq("out_tlast", {31'd0, out_tlast_s}, {31'd0, tl || (ebc == MAXB - 1)});
      ebc = (tl || ebc == MAXB - 1) ? 0 : ebc + 1;
    end
    AXIS_IN_TVALID = 1'b0;
    AXIS_IN_TLAST  = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 300 && hs_cnt < target; k++) tick();
    check_eq("len_handshake", {31'd0, hs_cnt >= target}, 1);
  endtask

  task automatic drain(input int k);
    repeat (k) begin
      wait_hs(done_cnt + 1);
      TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
      done_cnt++;
    end
  endtask

  initial begin
    int cnt, h0;
    tbl[0] = '{beats: 22, nlen: 1, len: '{16'd1408, 16'd0, 16'd0},    split: 1'b0};
    tbl[1] = '{beats: 1,  nlen: 1, len: '{16'd64, 16'd0, 16'd0},      split: 1'b0};
    tbl[2] = '{beats: 21, nlen: 1, len: '{16'd1344, 16'd0, 16'd0},    split: 1'b0};
    tbl[3] = '{beats: 50, nlen: 3, len: '{16'd1408, 16'd1408, 16'd384}, split: 1'b1};
    tbl[4] = '{beats: 23, nlen: 2, len: '{16'd1408, 16'd64, 16'd0},   split: 1'b1};

    rst = 1'b1; hold = 1'b0;
    AXIS_IN_TDATA = '0; AXIS_IN_TVALID = 1'b1; AXIS_IN_TLAST = 1'b0;
    AXIS_OUT_TREADY = 1'b1; AXIS_LEN_TREADY = 1'b1;
    TX_DONE = 1'b0; IFG_CYCLES = 16'd0; ENABLE = 1'b1;
    repeat (3) tick();
    check_eq("rst_in_tready", {31'd0, AXIS_IN_TREADY}, 0);
    check_eq("rst_out_tvalid", {31'd0, AXIS_OUT_TVALID}, 0);
    check_eq("rst_len_tvalid", {31'd0, AXIS_LEN_TVALID}, 0);
    check_eq("rst_len_full", {31'd0, LEN_FULL}, 0);
    check_eq("rst_oversplit", {31'd0, OVERSPLIT}, 0);
`ifdef UDP_SCHED_STATS_EN
    check_eq("rst_pkt_count", PKT_COUNT, 0);
    check_eq("rst_split_count", {16'd0, SPLIT_COUNT}, 0);
`endif
    AXIS_IN_TVALID = 1'b0;
    rst = 1'b0;
    tick();

    // 3-beat packet: TVALID rises two cycles after the TLAST cycle, one handshake only.
    exp_q.push_back(16'd192);
    send_beats(3, 1'b1);
    check_eq("lat_tvalid_e0", {31'd0, AXIS_LEN_TVALID}, 0);
    tick();
    check_eq("lat_tvalid_e1", {31'd0, AXIS_LEN_TVALID}, 1);
    check_eq("lat_tdata", {16'd0, AXIS_LEN_TDATA}, 192);
    drain(1);
    h0 = hs_cnt;
    repeat (6) tick();
    check_eq("single_hs", hs_cnt, h0);
    check_eq("oversplit_clean", {31'd0, OVERSPLIT}, 0);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < tbl[v].nlen; j++) exp_q.push_back(tbl[v].len[j]);
      send_beats(tbl[v].beats, 1'b1);
      drain(tbl[v].nlen);
      check_eq("oversplit_tbl", {31'd0, OVERSPLIT}, {31'd0, tbl[v].split});
    end

    // Inter-packet gap: N=10 -> TVALID in cycle 12 after TX_DONE; N=0 -> cycle 2.
    repeat (3) exp_q.push_back(16'd64);
    send_beats(1, 1'b1);
    send_beats(1, 1'b1);
    send_beats(1, 1'b1);
    wait_hs(done_cnt + 1);
    tick();
    IFG_CYCLES = 16'd10; TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0; IFG_CYCLES = 16'd0; cnt = 1;
    while (!AXIS_LEN_TVALID && cnt < 40) begin tick(); cnt++; end
    check_eq("ifg10_delay", cnt, 12);
    done_cnt++;
    wait_hs(done_cnt + 1);
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0; cnt = 1;
    while (!AXIS_LEN_TVALID && cnt < 40) begin tick(); cnt++; end
    check_eq("ifg0_delay", cnt, 2);
    done_cnt++;
    drain(1);

    // Full FIFO: 16 lengths with the framer stalled, the 17th beat waits for a pop.
    AXIS_LEN_TREADY = 1'b0;
    for (int p = 0; p < 16; p++) begin exp_q.push_back(16'd64); send_beats(1, 1'b1); end
    check_eq("len_full_16", {31'd0, LEN_FULL}, 1);
    exp_q.push_back(16'd64);
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TLAST = 1'b1;
    repeat (3) begin
      tick();
      check_eq("full_stall", {31'd0, in_hs | AXIS_IN_TREADY}, 0);
    end
    AXIS_LEN_TREADY = 1'b1;
    tick();
    AXIS_LEN_TREADY = 1'b0;
    tick();
    check_eq("beat17_accept", {31'd0, in_hs}, 1);
    check_eq("len_full_refill", {31'd0, LEN_FULL}, 1);
    AXIS_IN_TVALID = 1'b0; AXIS_IN_TLAST = 1'b0;
    AXIS_LEN_TREADY = 1'b1;
    drain(17);

    // ENABLE gating, then reset while BUSY.
    ENABLE = 1'b0;
    exp_q.push_back(16'd64);
    send_beats(1, 1'b1);
    send_beats(1, 1'b1);
    h0 = hs_cnt;
    repeat (5) tick();
    check_eq("disabled_tvalid", {31'd0, AXIS_LEN_TVALID}, 0);
    check_eq("disabled_hs", hs_cnt, h0);
    AXIS_LEN_TREADY = 1'b0; ENABLE = 1'b1;
    tick();
    check_eq("enable_tvalid", {31'd0, AXIS_LEN_TVALID}, 1);
    AXIS_LEN_TREADY = 1'b1;
    tick();
    check_eq("busy_hs", hs_cnt, h0 + 1);
    rst = 1'b1;
    tick();
    check_eq("rstbusy_tvalid", {31'd0, AXIS_LEN_TVALID}, 0);
    check_eq("rstbusy_full", {31'd0, LEN_FULL}, 0);
    check_eq("rstbusy_oversplit", {31'd0, OVERSPLIT}, 0);
    rst = 1'b0; done_cnt = hs_cnt; ebc = 0;
    repeat (4) tick();
    check_eq("rst_fifo_empty", {31'd0, AXIS_LEN_TVALID}, 0);

    // 50-beat split again from a clean state (statistics when built in).
    exp_q.push_back(16'd1408); exp_q.push_back(16'd1408); exp_q.push_back(16'd384);
    send_beats(50, 1'b1);
    drain(3);
    check_eq("split50_oversplit", {31'd0, OVERSPLIT}, 1);
`ifdef UDP_SCHED_STATS_EN
    check_eq("pkt_count", PKT_COUNT, 3);
    check_eq("split_count", {16'd0, SPLIT_COUNT}, 2);
    check_eq("stall_cycles", STALL_CYCLES, 0);
`endif
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
